// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic lamp monitor and the light controller:
// FSM state encodings, fault codes, default limits and a popcount helper.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_RUN      = 2'd1,
        ST_CONFLICT = 2'd2,
        ST_FAULT    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_CONFLICT = 2'b01,
        FAULT_DARK     = 2'b10
    } fault_code_e;

    localparam logic [35:0] DEF_CONFLICT_LIMIT = 36'd4;
    localparam logic [35:0] DEF_DARK_LIMIT     = 36'd4000000000;
    localparam logic [35:0] DEF_BLINK_HALF     = 36'd500000000;
    localparam logic [7:0]  DEF_DIM_DUTY       = 8'd192;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/traffic_blink_gen.sv
// Fault blink generator: phase starts ON after restart and toggles
// every BLINK_HALF cycles while restart is low.
module traffic_blink_gen
    import traffic_light_pkg::*;
#(
    parameter logic [35:0] BLINK_HALF = DEF_BLINK_HALF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic phase_o
);

    logic [35:0] cnt_q, cnt_d;
    logic        phase_q, phase_d;

    // Restart holds the counter at zero with the phase ON.
    always_comb begin
        cnt_d   = cnt_q + 36'd1;
        phase_d = phase_q;
        if (restart_i) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == BLINK_HALF - 36'd1) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Lamp monitor: registers light requests, drives lamps, latches faults.
// Optional macro TRAFFIC_LAMP_DIM_EN gates all lamps with a PWM duty.
module traffic_lamp_monitor
    import traffic_light_pkg::*;
#(
    parameter logic [35:0] CONFLICT_LIMIT = DEF_CONFLICT_LIMIT,
    parameter logic [35:0] DARK_LIMIT     = DEF_DARK_LIMIT,
    parameter logic [35:0] BLINK_HALF     = DEF_BLINK_HALF,
    parameter logic [7:0]  DIM_DUTY       = DEF_DIM_DUTY
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       RED_I,
    input  logic       YELLOW_I,
    input  logic       GREEN_I,
    input  logic       FAULT_CLR_I,
    output logic       RED_LAMP_O,
    output logic       YELLOW_LAMP_O,
    output logic       GREEN_LAMP_O,
    output logic       FAULT_O,
    output logic [1:0] FAULT_CODE_O
);

    logic [2:0]  req_q;
    logic [1:0]  pop;
    state_e      state_q, state_d;
    logic [35:0] dark_q, dark_d;
    logic [35:0] conf_q, conf_d;
    logic [2:0]  lamp_q, lamp_d;
    logic        fault_q, fault_d;
    fault_code_e code_q, code_d;
    logic        blink_restart;
    logic        blink_phase;
    logic        red_raw;
    logic        lamp_en;

    assign pop = popcount3(req_q);

    // Sample requests once; every decision below uses req_q.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) req_q <= '0;
        else       req_q <= {RED_I, YELLOW_I, GREEN_I};
    end

    // Next state, run counters, fault latch and lamp pattern.
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        code_d  = code_q;
        lamp_d  = 3'b000;
        dark_d  = '0;
        conf_d  = '0;
        if (state_q != ST_FAULT && pop == 2'd0)
            dark_d = dark_q + 36'd1;
        if (state_q != ST_FAULT && pop >= 2'd2)
            conf_d = conf_q + 36'd1;
        unique case (state_q)
            ST_FAULT: begin
                if (FAULT_CLR_I && pop == 2'd1) begin
                    state_d = ST_RUN;
                    fault_d = 1'b0;
                    code_d  = FAULT_NONE;
                end
            end
            default: begin
                if (state_q == ST_OFF && pop == 2'd0 &&
                    dark_q == DARK_LIMIT - 36'd1) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    code_d  = FAULT_DARK;
                end else if (state_q == ST_CONFLICT &&
                             pop >= 2'd2 &&
                             conf_q == CONFLICT_LIMIT - 36'd1) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    code_d  = FAULT_CONFLICT;
                end else if (pop == 2'd0) begin
                    state_d = ST_OFF;
                end else if (pop == 2'd1) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CONFLICT;
                end
            end
        endcase
        if (state_d == ST_FAULT) begin
            dark_d = '0;
            conf_d = '0;
        end
        unique case (state_d)
            ST_RUN:      lamp_d = req_q;
            ST_CONFLICT: lamp_d = 3'b100;
            default:     lamp_d = 3'b000;
        endcase
    end

    // State, counters, lamps and fault registers.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= ST_OFF;
            dark_q  <= '0;
            conf_q  <= '0;
            lamp_q  <= '0;
            fault_q <= 1'b0;
            code_q  <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            dark_q  <= dark_d;
            conf_q  <= conf_d;
            lamp_q  <= lamp_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    assign blink_restart = (state_q != ST_FAULT);

    traffic_blink_gen #(
        .BLINK_HALF(BLINK_HALF)
    ) u_blink (
        .clk_i    (CLK_I),
        .rst_i    (RST_I),
        .restart_i(blink_restart),
        .phase_o  (blink_phase)
    );

    assign red_raw = fault_q ? blink_phase : lamp_q[2];

`ifdef TRAFFIC_LAMP_DIM_EN
    logic [7:0] pwm_q;

    // Free-running PWM counter for lamp dimming.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) pwm_q <= '0;
        else       pwm_q <= pwm_q + 8'd1;
    end

    assign lamp_en = (pwm_q < DIM_DUTY);
`else
    logic unused_dim;
    assign unused_dim = ^DIM_DUTY;
    assign lamp_en    = 1'b1;
`endif

    assign RED_LAMP_O    = red_raw & lamp_en;
    assign YELLOW_LAMP_O = lamp_q[1] & lamp_en;
    assign GREEN_LAMP_O  = lamp_q[0] & lamp_en;
    assign FAULT_O       = fault_q;
    assign FAULT_CODE_O  = code_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Bench for traffic_lamp_monitor: cycle model plus directed literal checks.
// Build with TRAFFIC_LAMP_DIM_EN defined to exercise the PWM duty check.
module tb_traffic_lamp_monitor;

    localparam logic [35:0] CL = 36'd4;
    localparam logic [35:0] DL = 36'd100;
    localparam logic [35:0] BH = 36'd10;
    localparam logic [7:0]  DD = 8'd64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r = 1'b0, y = 1'b0, g = 1'b0, clr = 1'b0;
    logic       rl, yl, gl, fo;
    logic [1:0] fc;
    int         n_tests = 0;
    int         n_fail = 0;
    bit         done = 1'b0;

    always #5 clk = ~clk;

    traffic_lamp_monitor #(
        .CONFLICT_LIMIT(CL),
        .DARK_LIMIT    (DL),
        .BLINK_HALF    (BH),
        .DIM_DUTY      (DD)
    ) dut (
        .CLK_I        (clk),
        .RST_I        (rst),
        .RED_I        (r),
        .YELLOW_I     (y),
        .GREEN_I      (g),
        .FAULT_CLR_I  (clr),
        .RED_LAMP_O   (rl),
        .YELLOW_LAMP_O(yl),
        .GREEN_LAMP_O (gl),
        .FAULT_O      (fo),
        .FAULT_CODE_O (fc)
    );

    // Behavioural model: mode 0 off, 1 run, 2 conflict, 3 fault.
    int         m_mode, m_zrun, m_crun, m_age, m_pwm;
    logic [2:0] m_req, m_lamps;
    logic       m_fault;
    logic [1:0] m_code;

    function automatic int pc(input logic [2:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]);
    endfunction

    function automatic logic gate();
`ifdef TRAFFIC_LAMP_DIM_EN
        return m_pwm < int'(DD);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic lg(input logic v);
        return v & gate();
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int p;
        if (rst) begin
            m_mode = 0; m_zrun = 0; m_crun = 0; m_age = 0; m_pwm = 0;
            m_req = 3'b000; m_lamps = 3'b000;
            m_fault = 1'b0; m_code = 2'b00;
        end else begin
            p = pc(m_req);
            m_pwm = (m_pwm + 1) % 256;
            if (m_mode == 3) begin
                m_age++;
                if (clr && p == 1) begin
                    m_mode = 1; m_fault = 1'b0; m_code = 2'b00;
                    m_lamps = m_req;
                end
            end else begin
                m_zrun = (p == 0) ? m_zrun + 1 : 0;
                m_crun = (p >= 2) ? m_crun + 1 : 0;
                if ((m_mode == 0 && m_zrun == int'(DL)) ||
                    (m_mode == 2 && m_crun == int'(CL))) begin
                    m_code  = (m_mode == 0) ? 2'b10 : 2'b01;
                    m_mode  = 3; m_fault = 1'b1; m_lamps = 3'b000;
                    m_age   = 0; m_zrun = 0; m_crun = 0;
                end else begin
                    m_mode  = (p == 0) ? 0 : (p == 1) ? 1 : 2;
                    m_lamps = (m_mode == 1) ? m_req :
                              (m_mode == 2) ? 3'b100 : 3'b000;
                end
            end
            m_req = {r, y, g};
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Compare every output against the model each cycle.
    always @(negedge clk) begin
        if (!done) begin
            check("m_red", 32'(rl), 32'(lg(m_mode == 3 ?
                  ((m_age / int'(BH)) % 2 == 0) : m_lamps[2])));
            check("m_yel", 32'(yl), 32'(lg(m_lamps[1])));
            check("m_grn", 32'(gl), 32'(lg(m_lamps[0])));
            check("m_flt", 32'(fo), 32'(m_fault));
            check("m_code", 32'(fc), 32'(m_code));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        step(2);
        check("rst_red", 32'(rl), 0);
        check("rst_flt", 32'(fo), 0);
        check("rst_code", 32'(fc), 0);
        rst = 1'b0;
        r = 1'b1;
        step(1);
        check("lat1_red", 32'(rl), 0);
        step(1);
        check("lat2_red", 32'(rl), 32'(lg(1'b1)));
        check("lat2_flt", 32'(fo), 0);

        g = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("c3_red", 32'(rl), 32'(lg(1'b1)));
            check("c3_grn", 32'(gl), 0);
        end
        g = 1'b0;
        step(6);
        check("c3_after_red", 32'(rl), 32'(lg(1'b1)));
        check("c3_after_flt", 32'(fo), 0);

        g = 1'b1;
        step(4);
        check("c4_noflt", 32'(fo), 0);
        g = 1'b0;
        step(1);
        check("c4_flt", 32'(fo), 1);
        check("c4_code", 32'(fc), 1);
        check("c4_red", 32'(rl), 32'(lg(1'b1)));

        r = 1'b0;
        step(2);
        clr = 1'b1;
        step(2);
        check("clr_bad_flt", 32'(fo), 1);
        check("clr_bad_code", 32'(fc), 1);
        g = 1'b1;
        step(1);
        check("clr_wait_flt", 32'(fo), 1);
        step(1);
        check("clr_ok_flt", 32'(fo), 0);
        check("clr_ok_code", 32'(fc), 0);
        check("clr_ok_grn", 32'(gl), 32'(lg(1'b1)));
        clr = 1'b0;

        g = 1'b0;
        step(99);
        y = 1'b1;
        step(1);
        check("d99_flt", 32'(fo), 0);
        step(1);
        check("d99_yel", 32'(yl), 32'(lg(1'b1)));
        check("d99_flt2", 32'(fo), 0);

        y = 1'b0;
        step(100);
        check("d100_pre", 32'(fo), 0);
        step(1);
        check("d100_flt", 32'(fo), 1);
        check("d100_code", 32'(fc), 2);
        check("blink0", 32'(rl), 32'(lg(1'b1)));
        step(9);
        check("blink9", 32'(rl), 32'(lg(1'b1)));
        step(1);
        check("blink10", 32'(rl), 0);
        step(9);
        check("blink19", 32'(rl), 0);
        step(1);
        check("blink20", 32'(rl), 32'(lg(1'b1)));

        step(5);
        #2 rst = 1'b1;
        #1;
        check("arst_red", 32'(rl), 0);
        check("arst_yel", 32'(yl), 0);
        check("arst_grn", 32'(gl), 0);
        check("arst_flt", 32'(fo), 0);
        check("arst_code", 32'(fc), 0);
        @(negedge clk);
        rst = 1'b0;
        step(99);
        check("rdark_pre", 32'(fo), 0);
        step(1);
        check("rdark_flt", 32'(fo), 1);
        check("rdark_code", 32'(fc), 2);

        r = 1'b1;
        clr = 1'b1;
        step(2);
        check("rec_flt", 32'(fo), 0);
        check("rec_red", 32'(rl), 32'(lg(1'b1)));
        clr = 1'b0;
        step(2);

`ifdef TRAFFIC_LAMP_DIM_EN
        begin
            int hi;
            hi = 0;
            for (int i = 0; i < 256; i++) begin
                step(1);
                if (rl) hi++;
            end
            check("pwm_duty", 32'(hi), 32'(DD));
        end
`endif

        done = 1'b1;
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
